// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor helper used by the baud tick generator.
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
  localparam int unsigned DEFAULT_BAUD = 9600;
  localparam int unsigned OVS_FACTOR   = 16;
  localparam int unsigned DEFAULT_DIV  = 325;

  // Sample-tick divisor for a given baud rate (truncating division).
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * OVS_FACTOR);
  endfunction

endpackage

// File: rtl/div_shadow_reg.sv
// Shadow register for runtime divisor updates: valid/ready intake, zero
// rejection, and a pending flag that the counter side clears by applying.
module div_shadow_reg
  import uart_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] div_i,
  input  logic             div_valid_i,
  input  logic             apply_i,
  output logic             div_ready_o,
  output logic             div_err_o,
  output logic [Width-1:0] new_div_o
);

  logic [Width-1:0] r_shadow;
  logic             r_pending;
  logic             r_err;
  logic             w_accept;
  logic             w_zero;

  assign w_accept    = div_valid_i & ~r_pending;
  assign w_zero      = (div_i == '0);
  assign div_ready_o = ~r_pending;
  assign div_err_o   = r_err;
  assign new_div_o   = r_shadow;

  // Capture non-zero requests, flag zero requests for one cycle, release on apply.
  // apply_i is only raised while pending, and accept only happens while not
  // pending, so the two never collide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept & w_zero;
      if (apply_i) begin
        r_pending <= 1'b0;
      end else if (w_accept && !w_zero) begin
        r_shadow  <= div_i;
        r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_baud_gen.sv
// Runtime-programmable sample/bit tick generator. A sample tick fires every
// div_o enabled cycles and a bit tick on every OvsFactor-th sample tick. New
// divisors wait in a shadow register and switch in only at a period boundary,
// on clear, or while counting is disabled, so no period is ever cut short.
module prog_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned Width      = 16,
  parameter int unsigned DefaultDiv = DEFAULT_DIV,
  parameter int unsigned OvsFactor  = OVS_FACTOR,
  parameter int unsigned OvsWidth   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [Width-1:0]    div_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  output logic                div_err_o,
  output logic [Width-1:0]    div_o,
  output logic                tick_o,
  output logic                bit_tick_o,
  output logic [OvsWidth-1:0] ovs_o
);

  localparam logic [Width-1:0]    DIV_RST  = Width'(DefaultDiv);
  localparam logic [OvsWidth-1:0] OVS_LAST = OvsWidth'(OvsFactor - 1);

  logic [Width-1:0]    r_cnt;
  logic [OvsWidth-1:0] r_ovs;
  logic [Width-1:0]    r_div;

  logic                w_wrap;
  logic                w_ovs_last;
  logic                w_pending;
  logic                w_apply;
  logic [Width-1:0]    w_new_div;

  // >= rather than == keeps the counter from running past a shrunken bound.
  assign w_wrap     = (r_cnt >= (r_div - Width'(1)));
  assign w_ovs_last = (r_ovs == OVS_LAST);
  assign tick_o     = en_i & ~clr_i & w_wrap;
  assign bit_tick_o = tick_o & w_ovs_last;
  assign w_pending  = ~div_ready_o;
  assign w_apply    = w_pending & (tick_o | clr_i | ~en_i);
  assign div_o      = r_div;
  assign ovs_o      = r_ovs;

  div_shadow_reg #(
    .Width(Width)
  ) u_shadow (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .apply_i     (w_apply),
    .div_ready_o (div_ready_o),
    .div_err_o   (div_err_o),
    .new_div_o   (w_new_div)
  );

  // Sample and oversample counters; clear beats enable, and an apply while
  // idle restarts the sample count so the first new period is full length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ovs <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_ovs <= '0;
    end else if (en_i && w_wrap) begin
      r_cnt <= '0;
      r_ovs <= w_ovs_last ? '0 : r_ovs + OvsWidth'(1);
    end else if (en_i) begin
      r_cnt <= r_cnt + Width'(1);
    end else if (w_apply) begin
      r_cnt <= '0;
    end
  end

  // Active divisor switches only when the pending shadow is applied.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div <= DIV_RST;
    end else if (w_apply) begin
      r_div <= w_new_div;
    end
  end

endmodule
